// File: rtl/axi4_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi4_mem_responder_pkg
// Shared types for the memory-side AXI4 responder: address/data words, byte
// strobes and the AXI response code with its two values used here.
// -----------------------------------------------------------------------------
package axi4_mem_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;

    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

    // Map an address-error flag onto the AXI response code.
    function automatic axi_resp_t resp_of(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage : axi4_mem_responder_pkg

// File: rtl/axi4_mem_responder_sram.sv
// -----------------------------------------------------------------------------
// sram_be_1rw
// Single-port synchronous RAM, 32-bit words, 4 byte enables, registered read.
// One access per cycle: en_i & we_i writes the enabled bytes, en_i & !we_i
// loads the read register. The read register holds its value while idle.
//
// Ports:
//   clk_i    clock
//   en_i     access enable
//   we_i     1 = write, 0 = read
//   addr_i   word index
//   be_i     byte enables for writes
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module sram_be_1rw
    import axi4_mem_responder_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  strb_t            be_i,
    input  word_t            wdata_i,
    output word_t            rdata_o
);

    word_t mem [WORDS];
    word_t rdata_q;

    // NOTE: the storage array has no reset; clearing it would turn the block
    // into thousands of flops instead of a RAM macro, and contents are
    // defined by software writes anyway.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : sram_be_1rw

// File: rtl/axi4_mem_responder.sv
// -----------------------------------------------------------------------------
// axi4_mem_responder
// Single-outstanding AXI4 subordinate serving reads and writes from an
// on-chip word-addressed SRAM. Round-robin arbitration between AR and AW,
// byte-strobed writes, fixed read latency, OKAY/SLVERR responses.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   arvalid_i/arready_o, araddr_i      read address channel (arprot_i ignored)
//   rvalid_o/rready_i, rdata_o, rresp_o read data channel
//   awvalid_i/awready_o, awaddr_i      write address channel (awprot_i ignored)
//   wvalid_i/wready_o, wdata_i, wstrb_i write data channel
//   bvalid_o/bready_i, bresp_o         write response channel
// -----------------------------------------------------------------------------
module axi4_mem_responder
    import axi4_mem_responder_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            MEM_WORDS    = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter int unsigned            READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [2:0]            arprot_i,

    output logic                  rvalid_o,
    input  logic                  rready_i,
    output word_t                 rdata_o,
    output axi_resp_t             rresp_o,

    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [2:0]            awprot_i,

    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  word_t                 wdata_i,
    input  strb_t                 wstrb_i,

    output logic                  bvalid_o,
    input  logic                  bready_i,
    output axi_resp_t             bresp_o
);

    localparam int unsigned           IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    err_q, err_d;
    logic                    last_wr_q, last_wr_d;   // 1: last grant went to AW

    logic                    sel_rd, sel_wr;
    logic                    mem_en, mem_we;
    logic [IDX_W-1:0]        mem_idx;
    word_t                   mem_rdata;

    // Protection bits carry no meaning for this memory.
    logic prot_unused;
    assign prot_unused = ^{arprot_i, awprot_i};

    // Offset arithmetic wraps on underflow, so addresses below BASE_ADDR
    // land far above MEM_BYTES and are flagged as out of range.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || (off >= MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    // Round-robin: a lone valid wins; on a tie the channel not granted last wins.
    assign sel_rd = arvalid_i && (!awvalid_i || last_wr_q);
    assign sel_wr = awvalid_i && !sel_rd;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_d     = err_q;
        last_wr_d = last_wr_q;

        arready_o = 1'b0;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        rvalid_o  = 1'b0;
        bvalid_o  = 1'b0;
        rdata_o   = '0;
        rresp_o   = AXI_RESP_OKAY;
        bresp_o   = AXI_RESP_OKAY;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = word_idx(addr_q);

        unique case (state_q)
            IDLE: begin
                // Readys are gated by reset so nothing is accepted while it is held.
                arready_o = !rst_i && sel_rd;
                awready_o = !rst_i && sel_wr;
                if (arready_o) begin
                    addr_d    = araddr_i;
                    err_d     = addr_err(araddr_i);
                    last_wr_d = 1'b0;
                    // Start the SRAM read now; its output register then holds
                    // the word for the whole response phase.
                    mem_en    = !addr_err(araddr_i);
                    mem_idx   = word_idx(araddr_i);
                    if (READ_LATENCY <= 1) begin
                        state_d = RD_RESP;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 3'(READ_LATENCY - 1);
                    end
                end else if (awready_o) begin
                    addr_d    = awaddr_i;
                    err_d     = addr_err(awaddr_i);
                    last_wr_d = 1'b1;
                    state_d   = WR_DATA;
                end
            end

            RD_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RD_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            RD_RESP: begin
                rvalid_o = 1'b1;
                rdata_o  = err_q ? '0 : mem_rdata;
                rresp_o  = resp_of(err_q);
                if (rready_i) begin
                    state_d = IDLE;
                end
            end

            WR_DATA: begin
                wready_o = !rst_i;
                if (wready_o && wvalid_i) begin
                    mem_en  = !err_q;   // errored writes leave memory untouched
                    mem_we  = 1'b1;
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                bvalid_o = 1'b1;
                bresp_o  = resp_of(err_q);
                if (bready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b1;   // reads win the first tie
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
        end
    end

    sram_be_1rw #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_idx),
        .be_i    (wstrb_i),
        .wdata_i (wdata_i),
        .rdata_o (mem_rdata)
    );

endmodule : axi4_mem_responder

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

Single-outstanding AXI4 subordinate that terminates the instruction-side or data-side AXI4 master channels of the core's memory wrapper and serves them from an on-chip word-addressed SRAM. It provides the memory end of the fetch/LSU path for simulation, FPGA bring-up and tightly-coupled memory. It arbitrates read and write channels, applies byte strobes, inserts a configurable read latency and returns OKAY/SLVERR responses.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; only 32 is supported
- MEM_WORDS, 1024, SRAM depth in words; must be a power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4
- READ_LATENCY, 1, cycles from AR handshake to first rvalid; legal range 1..4

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- arvalid_i / arready_o  in/out  1  read address handshake
- araddr_i  in  ADDR_WIDTH  read byte address
- arprot_i  in  3  accepted and ignored
- rvalid_o / rready_i  out/in  1  read data handshake
- rdata_o  out  32  read data
- rresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- awvalid_i / awready_o  in/out  1  write address handshake
- awaddr_i  in  ADDR_WIDTH  write byte address
- awprot_i  in  3  accepted and ignored
- wvalid_i / wready_o  in/out  1  write data handshake
- wdata_i  in  32  write data
- wstrb_i  in  4  byte enables
- bvalid_o / bready_i  out/in  1  write response handshake
- bresp_o  out  2  write response

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP. At most one transaction is in flight.
- IDLE: arready_o and awready_o are driven combinationally from the arbiter. Only the selected channel's ready is high.
- Arbitration: if only one of arvalid/awvalid is high, that channel is selected. If both are high, the channel not granted last is selected (round-robin). The last-grant flag resets to "write", so reads win the first tie.
- AR handshake: the address is latched and the address check is performed. With READ_LATENCY=1 the FSM goes to RD_RESP; otherwise it goes to RD_WAIT with the latency counter set to READ_LATENCY-1.
- RD_WAIT: the counter decrements each cycle. The FSM goes to RD_RESP when the counter reaches 1.
- RD_RESP: rvalid_o=1. rdata_o is the SRAM word, or 0 on error. On rready_i the FSM returns to IDLE.
- AW handshake: the address is latched and the FSM goes to WR_DATA.
- WR_DATA: wready_o=1. On W handshake, bytes with wstrb set are written, but only if the address is OK. The FSM then goes to WR_RESP.
- WR_RESP: bvalid_o=1. On bready_i the FSM returns to IDLE.
- Address error (SLVERR): addr[1:0]≠0, or (addr−BASE_ADDR) ≥ MEM_WORDS*4. Underflow counts as out of range. An errored write does not modify memory. An errored read returns rdata 0.
- Word index = (addr−BASE_ADDR)[log2(MEM_WORDS)+1:2].
- wstrb=0 on a valid address completes with OKAY and changes nothing.

## Timing
- Reset values: arready_o, awready_o, wready_o, rvalid_o and bvalid_o are 0 (the readys are 0 during rst_i regardless of valid). rdata_o=0, rresp_o=0, bresp_o=0. FSM is in IDLE and the latency counter is 0.
- SRAM contents are not reset.
- Read latency: AR handshake at cycle t gives rvalid_o=1 from cycle t+READ_LATENCY.
- Write: AW at t, earliest W at t+1, bvalid_o at the cycle after the W handshake.
- rdata_o/rresp_o and bresp_o stay stable while valid is high and ready is low.
- rvalid_o and bvalid_o deassert in the cycle after their handshake.
- Back-to-back: the next AR/AW can be accepted the cycle after an R or B handshake, not in the same cycle.
- A W beat presented before its AW is held off (wready_o=0) until WR_DATA.
- rst_i mid-transaction: the transaction is abandoned, outputs return to reset values next cycle, and no B or R is issued. A write already committed to SRAM stays.

## Structure
- The shared package gains axi_resp_t (2-bit) with constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10. The addr_t/word_t types already there are reused.
- The FSM state enum is local to the module.
- Sub-module sram_be_1rw holds the storage: synchronous single-port RAM with 4 byte enables, registered read, and one access per cycle.

## Test plan
- Single read: preload word 5 = 32'hDEAD_BEEF, READ_LATENCY=3, AR addr 0x14 at cycle 10 → rvalid_o at cycle 13, rdata=32'hDEAD_BEEF, rresp=00.
- Strobed write: word 2 = 32'h1122_3344, AW 0x8, W data 32'hAABB_CCDD strb 4'b0101 → bresp=00; readback gives 32'h11BB_33DD.
- Errors: read 0x1002 (misaligned), then write to 0x1000 with MEM_WORDS=1024 and BASE=0 → both return SLVERR; read of 0x1000 returns 0; memory unchanged.
- Simultaneous AR+AW in IDLE twice → first grant read, second grant write; a held-back channel's valid stays high until accepted.
- Backpressure: hold rready_i=0 for 5 cycles → rvalid_o and rdata_o are stable throughout; arready_o stays 0.
- Reset in WR_DATA (AW accepted, no W) → next cycle all outputs are at reset values, no bvalid_o, and a new read completes normally.
